// File: rtl/multi_delay_timer.sv
// Multi-channel delay timer: per-channel one-shot / periodic / level-hold countdown FSMs.
// Optional shared count-tick prescaler enabled by defining MULTI_DELAY_TIMER_PRESCALE_EN.
module multi_delay_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRE_W  = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
  input  logic [PRE_W-1:0]        prescale,
`endif
  input  logic [NUM_CH-1:0]       trigger,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH*CNT_W-1:0] delay_in,
  input  logic [2*NUM_CH-1:0]     mode_in,
  output logic [NUM_CH-1:0]       delayed_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [1:0] M_PERIODIC = 2'b01;
  localparam logic [1:0] M_HOLD     = 2'b10;

  logic [1:0]       state_q [NUM_CH];
  logic [1:0]       state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] dly_q   [NUM_CH];
  logic [CNT_W-1:0] dly_d   [NUM_CH];
  logic [1:0]       mode_q  [NUM_CH];
  logic [1:0]       mode_d  [NUM_CH];
  logic [NUM_CH-1:0] out_d, busy_d, done_d;
  logic             tick;

`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q;

  // >= rather than == so that lowering prescale mid-run cannot strand the counter above it
  assign tick = (pre_q >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= tick ? '0 : pre_q + PRE_W'(1);
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    mode_d  = mode_q;
    out_d   = delayed_out;
    done_d  = '0;
    busy_d  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cancel[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        out_d[i]   = 1'b0;
      end else if (trigger[i]) begin
        // a trigger also overrides an expiry due on this same edge, so no done pulse
        dly_d[i]   = delay_in[i*CNT_W +: CNT_W];
        mode_d[i]  = mode_in[2*i +: 2];
        cnt_d[i]   = delay_in[i*CNT_W +: CNT_W];
        out_d[i]   = 1'b0;
        state_d[i] = S_COUNT;
      end else begin
        case (state_q[i])
          S_COUNT: begin
            if (tick) begin
              if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
              end else begin
                done_d[i] = 1'b1;
                case (mode_q[i])
                  M_PERIODIC: begin
                    out_d[i] = ~delayed_out[i];
                    cnt_d[i] = dly_q[i];
                  end
                  M_HOLD: begin
                    out_d[i]   = 1'b1;
                    state_d[i] = S_HOLD;
                  end
                  default: begin
                    out_d[i]   = 1'b1;
                    state_d[i] = S_IDLE;
                  end
                endcase
              end
            end
          end
          S_HOLD:  out_d[i] = 1'b1;
          default: begin
            state_d[i] = S_IDLE;
            out_d[i]   = 1'b0;
          end
        endcase
      end
      busy_d[i] = (state_d[i] != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        dly_q[i]   <= '0;
        mode_q[i]  <= '0;
      end
      delayed_out <= '0;
      busy        <= '0;
      done        <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        dly_q[i]   <= dly_d[i];
        mode_q[i]  <= mode_d[i];
      end
      delayed_out <= out_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Scoreboard bench for multi_delay_timer: directed triggers push expected expiry events,
// a negedge monitor pops them whenever done pulses.
module tb_multi_delay_timer;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       trigger, cancel;
  logic [NUM_CH*CNT_W-1:0] delay_in;
  logic [2*NUM_CH-1:0]     mode_in;
  logic [NUM_CH-1:0]       delayed_out, busy, done;
`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
  logic [7:0]              prescale;
`endif

  multi_delay_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
    .prescale    (prescale),
`endif
    .trigger     (trigger),
    .cancel      (cancel),
    .delay_in    (delay_in),
    .mode_in     (mode_in),
    .delayed_out (delayed_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned ch;
    int unsigned lo;
    int unsigned hi;
    logic        out;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int unsigned ch, input int unsigned lo, input int unsigned hi,
                          input logic out);
    exp_t e;
    e.ch = ch; e.lo = lo; e.hi = hi; e.out = out;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive a trigger before the next rising edge; n is that edge's number.
  task automatic fire(input int unsigned ch, input int unsigned d, input logic [1:0] m,
                      output int unsigned n);
    delay_in[ch*CNT_W +: CNT_W] = d[CNT_W-1:0];
    mode_in[2*ch +: 2]          = m;
    trigger[ch]                 = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    trigger[ch] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (done[ch] === 1'b1) begin
          int idx;
          idx = -1;
          foreach (sb[k]) if (idx < 0 && sb[k].ch == ch) idx = k;
          n_vec++;
          if (idx < 0) begin
            n_err++;
            $display("FAIL unexpected_done ch%0d: done=1 at edge %0d, required no expiry", ch, cyc);
          end else begin
            if (cyc < sb[idx].lo || cyc > sb[idx].hi) begin
              n_err++;
              $display("FAIL expiry_edge ch%0d: got edge %0d, required %0d..%0d",
                       ch, cyc, sb[idx].lo, sb[idx].hi);
            end
            n_vec++;
            if (delayed_out[ch] !== sb[idx].out) begin
              n_err++;
              $display("FAIL expiry_out ch%0d: got %b, required %b at edge %0d",
                       ch, delayed_out[ch], sb[idx].out, cyc);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, m;
    reset    = 1'b1;
    trigger  = '0;
    cancel   = '0;
    delay_in = '0;
    mode_in  = '0;
`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
    prescale = '0;
`endif
    cycles(3);
    delay_in[0 +: CNT_W] = 16'd2;
    trigger[0] = 1'b1;
    cycles(2);
    reset   = 1'b0;
    trigger = '0;
    cycles(1);
    chk("reset_busy", {28'd0, busy}, 32'd0);
    chk("reset_out",  {28'd0, delayed_out}, 32'd0);
    chk("reset_done", {28'd0, done}, 32'd0);
    cycles(5);
    chk("trig_in_reset_ignored", {28'd0, busy}, 32'd0);

    // ch0 one-shot D=5; changing delay_in afterwards must not matter
    fire(0, 5, 2'b00, n);
    delay_in[0 +: CNT_W] = 16'd1;
    push_exp(0, n + 6, n + 6, 1'b1);
    wait_cyc(n + 5);
    chk("os_busy_mid", {31'd0, busy[0]}, 32'd1);
    chk("os_out_mid",  {31'd0, delayed_out[0]}, 32'd0);
    wait_cyc(n + 6);
    chk("os_out_exp",  {31'd0, delayed_out[0]}, 32'd1);
    chk("os_busy_exp", {31'd0, busy[0]}, 32'd0);
    wait_cyc(n + 7);
    chk("os_out_after", {31'd0, delayed_out[0]}, 32'd0);

    // ch1 periodic D=3: toggle every 4 clks
    fire(1, 3, 2'b01, n);
    push_exp(1, n + 4,  n + 4,  1'b1);
    push_exp(1, n + 8,  n + 8,  1'b0);
    push_exp(1, n + 12, n + 12, 1'b1);
    push_exp(1, n + 16, n + 16, 1'b0);
    wait_cyc(n + 6);
    chk("per_out_hi", {31'd0, delayed_out[1]}, 32'd1);
    chk("per_busy",   {31'd0, busy[1]}, 32'd1);
    wait_cyc(n + 10);
    chk("per_out_lo", {31'd0, delayed_out[1]}, 32'd0);
    chk("per_busy2",  {31'd0, busy[1]}, 32'd1);
    wait_cyc(n + 17);
    cancel[1] = 1'b1;
    @(negedge clk);
    cancel[1] = 1'b0;
    chk("per_cancel_busy", {31'd0, busy[1]}, 32'd0);
    chk("per_cancel_out",  {31'd0, delayed_out[1]}, 32'd0);

    // ch2 level-hold D=0, cancel 10 clks later
    fire(2, 0, 2'b10, n);
    push_exp(2, n + 1, n + 1, 1'b1);
    wait_cyc(n + 1);
    chk("hold_out",  {31'd0, delayed_out[2]}, 32'd1);
    chk("hold_busy", {31'd0, busy[2]}, 32'd1);
    wait_cyc(n + 11);
    chk("hold_out_held", {31'd0, delayed_out[2]}, 32'd1);
    cancel[2] = 1'b1;
    @(negedge clk);
    cancel[2] = 1'b0;
    chk("hold_cancel_out",  {31'd0, delayed_out[2]}, 32'd0);
    chk("hold_cancel_busy", {31'd0, busy[2]}, 32'd0);

    // ch3 retrigger at count 2 with D=10; ch0 cancel+trigger together
    delay_in[0*CNT_W +: CNT_W] = 16'd8;
    delay_in[3*CNT_W +: CNT_W] = 16'd6;
    mode_in = '0;
    trigger = 4'b1001;
    n = cyc + 1;
    @(negedge clk);
    trigger = '0;
    wait_cyc(n + 4);
    delay_in[3*CNT_W +: CNT_W] = 16'd10;
    trigger = 4'b1001;
    cancel  = 4'b0001;
    m = cyc + 1;
    push_exp(3, m + 11, m + 11, 1'b1);
    @(negedge clk);
    trigger = '0;
    cancel  = '0;
    chk("cxt_ch0_idle", {31'd0, busy[0]}, 32'd0);
    chk("retrig_busy",  {31'd0, busy[3]}, 32'd1);
    wait_cyc(m + 12);
    chk("retrig_done_idle", {31'd0, busy[3]}, 32'd0);
    chk("cxt_ch0_still_idle", {31'd0, busy[0]}, 32'd0);

    // trigger coincident with an expiry: restart, no done on that edge
    fire(0, 2, 2'b00, n);
    wait_cyc(n + 2);
    delay_in[0 +: CNT_W] = 16'd1;
    trigger[0] = 1'b1;
    m = n + 3;
    push_exp(0, m + 2, m + 2, 1'b1);
    @(negedge clk);
    trigger[0] = 1'b0;
    chk("coinc_no_done", {31'd0, done[0]}, 32'd0);
    chk("coinc_busy",    {31'd0, busy[0]}, 32'd1);
    wait_cyc(m + 3);

`ifdef MULTI_DELAY_TIMER_PRESCALE_EN
    prescale = 8'd3;
    fire(0, 2, 2'b00, n);
    push_exp(0, n + 9, n + 12, 1'b1);
    wait_cyc(n + 13);
    chk("pre_done_idle", {31'd0, busy[0]}, 32'd0);
    prescale = 8'd0;
`endif

    // asynchronous reset mid-count; trigger during reset is ignored
    fire(0, 20, 2'b00, n);
    cycles(5);
    chk("pre_reset_busy", {31'd0, busy[0]}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", {28'd0, busy}, 32'd0);
    chk("async_reset_out",  {28'd0, delayed_out}, 32'd0);
    chk("async_reset_done", {28'd0, done}, 32'd0);
    trigger[0] = 1'b1;
    @(negedge clk);
    cycles(2);
    reset   = 1'b0;
    trigger = '0;
    cycles(30);
    chk("no_resume_busy", {28'd0, busy}, 32'd0);

    cycles(3);
    foreach (sb[k]) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_done ch%0d: no expiry seen, required edge %0d..%0d",
               sb[k].ch, sb[k].lo, sb[k].hi);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_delay_timer.md
MULTI_DELAY_TIMER -- requirements
Module: multi_delay_timer

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of independent timer channels (1..16).
REQ-002 Parameter CNT_W, default 16, meaning delay counter width per channel (4..32).
REQ-003 Port clk  input  1  meaning system clock, all state updates on the rising edge.
REQ-004 Port reset  input  1  meaning reset, asynchronous, active-high.
REQ-005 Port trigger  input  NUM_CH  meaning per-channel start/restart strobe, sampled each clk edge.
REQ-006 Port cancel  input  NUM_CH  meaning per-channel abort strobe.
REQ-007 Port delay_in  input  NUM_CH*CNT_W  meaning per-channel delay value, channel i at bits [i*CNT_W +: CNT_W].
REQ-008 Port mode_in  input  2*NUM_CH  meaning per-channel mode, channel i at bits [2i +: 2]: 00 one-shot, 01 periodic toggle, 10 level-hold, 11 treated as one-shot.
REQ-009 Port delayed_out  output  NUM_CH  meaning per-channel timer output, registered.
REQ-010 Port busy  output  NUM_CH  meaning channel in COUNT or HOLD state, registered.
REQ-011 Port done  output  NUM_CH  meaning one-cycle pulse on each expiry event, registered.

Function
REQ-012 Each channel is an independent FSM with states IDLE, COUNT, HOLD; channels share only clk, reset and the prescaler.
REQ-013 On trigger[i] in any state, the channel latches delay_in and mode_in slices, loads the counter with the latched delay, clears delayed_out[i], and enters COUNT.
REQ-014 Later changes to delay_in/mode_in do not affect a running channel until the next trigger.
REQ-015 In COUNT, a nonzero counter decrements by 1 per count tick (every clk when prescaling is absent).
REQ-016 In COUNT, a zero counter on a count tick is an expiry: done[i] pulses high for exactly one clk.
REQ-017 One-shot expiry: delayed_out[i] is high for exactly one clk, and the channel returns to IDLE.
REQ-018 Periodic expiry: delayed_out[i] toggles, the counter reloads the latched delay, and the channel stays in COUNT indefinitely.
REQ-019 Level-hold expiry: delayed_out[i] goes high and stays high, and the channel enters HOLD until cancel or trigger.
REQ-020 Latency: trigger registered at edge N with delay D gives the first expiry at edge N+D+1 (unprescaled); D=0 expires at edge N+1.
REQ-021 Periodic mode output period is 2*(D+1) clks (unprescaled).
REQ-022 cancel[i] forces IDLE, counter 0, delayed_out[i]=0, done[i]=0 on the next edge.
REQ-023 Simultaneous cancel and trigger on one channel: cancel wins and the channel ends in IDLE.
REQ-024 Trigger coincident with an expiry: trigger wins, done is not pulsed, and the restart follows REQ-013.
REQ-025 Counter arithmetic is unsigned CNT_W bits and never wraps below 0.
REQ-026 In IDLE, all channel outputs are 0.
REQ-027 busy[i] is 1 exactly in COUNT or HOLD.

Reset
REQ-028 Assertion of reset immediately forces all channels to IDLE, all counters and latched values to 0, and delayed_out, busy, done to 0, regardless of clk.
REQ-029 A channel mid-count when reset asserts does not resume after deassertion, and triggers during reset are ignored.

Configuration
REQ-030 Macro MULTI_DELAY_TIMER_PRESCALE_EN, when defined, adds parameter PRE_W (default 8) and input port prescale (PRE_W bits) after reset.
REQ-031 With the macro defined, a shared free-running prescaler produces a count tick every prescale+1 clks (prescale=0 gives a tick every clk), and all COUNT-state decrements/expiries occur only on ticks.
REQ-032 With the macro defined, trigger, cancel and output registration stay per-clk, and the prescaler resets to 0 on reset and is not restarted by trigger.
REQ-033 Without the macro, the prescale port and logic are absent and every clk is a tick.

Verification
REQ-034 Reset held, then released, all channel outputs 0 -> busy=0, delayed_out=0, done=0 on all channels.
REQ-035 Ch0 one-shot D=5, trigger at edge N -> delayed_out[0] and done[0] high only after edge N+6 for one clk, then busy[0]=0.
REQ-036 Ch1 periodic D=3 -> delayed_out[1] toggles every 4 clks (period 8), done[1] pulses every 4 clks, with busy held.
REQ-037 Ch2 level-hold D=0 -> delayed_out[2] high after edge N+1 and held; cancel 10 clks later -> low and IDLE next edge.
REQ-038 Ch3 retriggered with D=10 at count=2, plus same-cycle cancel+trigger on ch0 -> ch3 expires 11 clks after retrigger, ch0 ends IDLE.
REQ-039 With MULTI_DELAY_TIMER_PRESCALE_EN defined, prescale=3, one-shot D=2 -> expiry 12 clks (±prescaler phase of 3) after trigger; async reset mid-count -> outputs 0 immediately, no later expiry.
